// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with a registered first-word-fall-through output stage,
// occupancy count and programmable almost flags. Optional sticky error flags
// are enabled with `define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_fwft #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 4,
   parameter int unsigned AE_LEVEL   = 4
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic                  winc,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  wfull,
   output logic                  almost_full,
   input  logic                  rinc,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rempty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   ,
   input  logic                  err_clr,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0]      r_wptr;
   logic [CNT_W-1:0]      r_rptr;
   logic [CNT_W-1:0]      r_count;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_rempty;
   logic                  r_wfull;
   logic                  r_almost_full;
   logic                  r_almost_empty;

   logic                  w_accept;
   logic                  w_pop;
   logic                  w_prefetch;
   logic [CNT_W-1:0]      w_mem_words;
   logic [CNT_W-1:0]      w_count_next;

   // Request qualification against the registered flags; prefetch refills the stage
   always_comb begin
      w_accept     = winc & ~r_wfull;
      w_pop        = rinc & ~r_rempty;
      w_mem_words  = r_wptr - r_rptr;
      w_prefetch   = (w_mem_words != '0) & (r_rempty | w_pop);
      w_count_next = r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
   end

   // Storage array is intentionally not reset
   always_ff @(posedge wclk) begin
      if (w_accept) begin
         r_mem[r_wptr[ADDR_WIDTH-1:0]] <= wdata;
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_count        <= '0;
         r_rdata        <= '0;
         r_rempty       <= 1'b1;
         r_wfull        <= 1'b0;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
      end else begin
         if (w_accept) begin
            r_wptr <= r_wptr + CNT_W'(1);
         end
         if (w_prefetch) begin
            r_rdata  <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
            r_rptr   <= r_rptr + CNT_W'(1);
            r_rempty <= 1'b0;
         end else if (w_pop) begin
            r_rempty <= 1'b1;
         end
         r_count        <= w_count_next;
         r_wfull        <= (w_count_next == CNT_W'(DEPTH));
         r_almost_full  <= (w_count_next >= CNT_W'(AF_LEVEL));
         r_almost_empty <= (w_count_next <= CNT_W'(AE_LEVEL));
      end
   end

   assign wfull        = r_wfull;
   assign almost_full  = r_almost_full;
   assign rdata        = r_rdata;
   assign rempty       = r_rempty;
   assign almost_empty = r_almost_empty;
   assign count        = r_count;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky error flags; a new error in the clearing cycle takes priority
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (winc && r_wfull) begin
            r_overflow <= 1'b1;
         end else if (err_clr) begin
            r_overflow <= 1'b0;
         end
         if (rinc && r_rempty) begin
            r_underflow <= 1'b1;
         end else if (err_clr) begin
            r_underflow <= 1'b0;
         end
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Randomised scoreboard bench for sync_fifo_fwft (ADDR_WIDTH=3) against a
// queue-based reference model of the FWFT FIFO.
module tb_sync_fifo_fwft;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 3;
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned AFL   = DEPTH - 4;
   localparam int unsigned AEL   = 4;

   logic          wclk;
   logic          wrst;
   logic          winc;
   logic [DW-1:0] wdata;
   logic          wfull;
   logic          almost_full;
   logic          rinc;
   logic [DW-1:0] rdata;
   logic          rempty;
   logic          almost_empty;
   logic [AW:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic          err_clr;
   logic          overflow;
   logic          underflow;
   logic          m_ovf;
   logic          m_unf;
`endif

   sync_fifo_fwft #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .wclk        (wclk),
      .wrst        (wrst),
      .winc        (winc),
      .wdata       (wdata),
      .wfull       (wfull),
      .almost_full (almost_full),
      .rinc        (rinc),
      .rdata       (rdata),
      .rempty      (rempty),
      .almost_empty(almost_empty),
      .count       (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      ,
      .err_clr     (err_clr),
      .overflow    (overflow),
      .underflow   (underflow)
`endif
   );

   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   // Model entry: word plus the edge index at which it was written
   typedef struct {
      logic [DW-1:0] d;
      int            t;
   } ent_t;

   ent_t          model_q[$];
   logic [DW-1:0] sb_q[$];
   int            n_edges = 0;
   int            n_checks = 0;
   int            n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A word becomes visible one edge after it was written
   function automatic logic model_empty();
      if (model_q.size() == 0) return 1'b1;
      return (model_q[0].t == n_edges);
   endfunction

   task automatic check_state();
      logic e;
      e = model_empty();
      chk("count", 64'(count), 64'(model_q.size()));
      chk("rempty", 64'(rempty), 64'(e));
      chk("wfull", 64'(wfull), 64'(model_q.size() == DEPTH));
      chk("almost_full", 64'(almost_full), 64'(model_q.size() >= AFL));
      chk("almost_empty", 64'(almost_empty), 64'(model_q.size() <= AEL));
      if (!e) chk("rdata_head", 64'(rdata), 64'(model_q[0].d));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("underflow", 64'(underflow), 64'(m_unf));
`endif
   endtask

   // Called at a falling edge: check, drive one cycle of requests, advance model
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
      logic pop;
      logic acc;
      check_state();
      winc  = w;
      wdata = d;
      rinc  = r;
      pop   = r && !model_empty();
      acc   = w && (model_q.size() < DEPTH);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      if (w && model_q.size() == DEPTH) m_ovf = 1'b1;
      if (r && model_empty()) m_unf = 1'b1;
`endif
      if (pop) void'(model_q.pop_front());
      if (acc) begin
         model_q.push_back('{d: d, t: n_edges + 1});
         sb_q.push_back(d);
      end
      @(posedge wclk);
      n_edges++;
      @(negedge wclk);
      winc = 1'b0;
      rinc = 1'b0;
   endtask

   task automatic check_reset_values();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_rempty", 64'(rempty), 64'd1);
      chk("rst_wfull", 64'(wfull), 64'd0);
      chk("rst_almost_full", 64'(almost_full), 64'd0);
      chk("rst_almost_empty", 64'(almost_empty), 64'd1);
      chk("rst_rdata", 64'(rdata), 64'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_underflow", 64'(underflow), 64'd0);
`endif
   endtask

   task automatic clear_model();
      model_q.delete();
      sb_q.delete();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      m_ovf = 1'b0;
      m_unf = 1'b0;
`endif
   endtask

   // Monitor: every accepted pop must present the oldest outstanding write
   always @(posedge wclk) begin
      if (!wrst && rinc && !rempty) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL pop_data: got 0x%0h expected no word (t=%0t)", rdata, $time);
         end else begin
            if (rdata !== sb_q[0]) begin
               n_errors++;
               $display("FAIL pop_data: got 0x%0h expected 0x%0h (t=%0t)", rdata, sb_q[0], $time);
            end
            void'(sb_q.pop_front());
         end
      end
   end

   initial begin
      wrst  = 1'b1;
      winc  = 1'b0;
      rinc  = 1'b0;
      wdata = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      err_clr = 1'b0;
`endif
      clear_model();
      repeat (2) @(negedge wclk);
      check_reset_values();
      wrst = 1'b0;
      repeat (3) step(1'b0, '0, 1'b0);

      // Single write: visible after the following edge
      step(1'b1, 32'hA5A5_0001, 1'b0);
      step(1'b0, '0, 1'b0);
      chk("single_rdata", 64'(rdata), 64'h0000_0000_A5A5_0001);
      chk("single_count", 64'(count), 64'd1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      // Fill, overfill, drain
      for (int i = 0; i < 8; i++) step(1'b1, DW'(i), 1'b0);
      step(1'b1, 32'h0000_DEAD, 1'b0);
      chk("full_wfull", 64'(wfull), 64'd1);
      chk("full_count", 64'(count), 64'd8);
      for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1);
      chk("drained_rempty", 64'(rempty), 64'd1);

      // Full with simultaneous write and pop
      for (int i = 0; i < 8; i++) step(1'b1, DW'(32'h50 + i), 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b1, 32'h0000_BEEF, 1'b1);
      chk("fullrw_count", 64'(count), 64'd7);
      chk("fullrw_wfull", 64'(wfull), 64'd0);
      for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1);

      // Streaming across several pointer wraps
      for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h200 + i), 1'b0);
      for (int i = 0; i < 40; i++) step(1'b1, DW'(32'h100 + i), 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

      // Randomised traffic with varying write/read bias
      for (int i = 0; i < 400; i++) begin
         int wb;
         wb = (i / 100) % 2 == 0 ? 70 : 30;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
         err_clr = ($urandom_range(0, 19) == 0);
         if (err_clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
`endif
         step(($urandom_range(0, 99) < wb), $urandom, ($urandom_range(0, 99) >= wb - 20));
      end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      err_clr = 1'b0;
`endif
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);

      // Reset with words held
      for (int i = 0; i < 5; i++) step(1'b1, DW'(32'h300 + i), 1'b0);
      step(1'b0, '0, 1'b0);
      chk("pre_reset_count", 64'(count), 64'd5);
      wrst = 1'b1;
      #1;
      check_reset_values();
      clear_model();
      @(negedge wclk);
      wrst = 1'b0;
      step(1'b1, 32'h0000_1234, 1'b0);
      step(1'b0, '0, 1'b0);
      chk("post_reset_rdata", 64'(rdata), 64'h0000_0000_0000_1234);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
